// File: rtl/dm_periph_pkg.sv
// Shared definitions for dm-bus responder peripherals: register offsets,
// CTRL bit positions, bus FSM states and the byte-lane merge helper.
package dm_periph_pkg;

  localparam logic [1:0] REG_COUNT   = 2'd0;
  localparam logic [1:0] REG_COMPARE = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  localparam int unsigned CTRL_ENABLE      = 0;
  localparam int unsigned CTRL_IRQ_EN      = 1;
  localparam int unsigned CTRL_AUTO_RELOAD = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } bus_state_e;

  function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  mask);
    logic [31:0] r;
    r = old_v;
    for (int unsigned i = 0; i < 4; i++) begin
      if (mask[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dm_timer_core.sv
// Timer datapath: prescaler, COUNT/COMPARE/CTRL/STATUS registers, match
// detection and level IRQ, updated through a single write strobe.
module dm_timer_core
  import dm_periph_pkg::*;
#(
  parameter int unsigned PRESCALE = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_en_i,
  input  logic [1:0]  wr_addr_i,
  input  logic [31:0] wr_data_i,
  input  logic [3:0]  wr_mask_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [2:0]  ctrl_o,
  output logic        match_o,
  output logic        irq_o
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   count_q, count_d;
  logic [31:0]   compare_q, compare_d;
  logic [2:0]    ctrl_q, ctrl_d;
  logic          match_q, match_d;
  logic          tick;
  logic          match_set;

  always_comb begin
    presc_d   = presc_q;
    count_d   = count_q;
    compare_d = compare_q;
    ctrl_d    = ctrl_q;
    match_d   = match_q;
    tick      = 1'b0;
    match_set = 1'b0;

    if (ctrl_q[CTRL_ENABLE]) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    if (tick) begin
      if (count_q == compare_q) begin
        match_set = 1'b1;
        count_d   = ctrl_q[CTRL_AUTO_RELOAD] ? '0 : count_q + 32'd1;
      end else begin
        count_d   = count_q + 32'd1;
      end
    end

    // CPU writes override the tick; match set is applied last so it beats W1C.
    if (wr_en_i) begin
      case (wr_addr_i)
        REG_COUNT: begin
          count_d = merge_be(count_q, wr_data_i, wr_mask_i);
          presc_d = '0;
        end
        REG_COMPARE: compare_d = merge_be(compare_q, wr_data_i, wr_mask_i);
        REG_CTRL:    if (wr_mask_i[0]) ctrl_d = wr_data_i[2:0];
        REG_STATUS:  if (wr_mask_i[0] && wr_data_i[0]) match_d = 1'b0;
        default: ;
      endcase
    end

    if (match_set) match_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q   <= '0;
      count_q   <= '0;
      compare_q <= '1;
      ctrl_q    <= '0;
      match_q   <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ctrl_q    <= ctrl_d;
      match_q   <= match_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ctrl_o    = ctrl_q;
  assign match_o   = match_q;
  assign irq_o     = match_q & ctrl_q[CTRL_IRQ_EN];

endmodule

// File: rtl/dm_timer_responder.sv
// Timer peripheral on the urv_cpu dm bus: wait-state bus FSM and read mux
// in front of the timer core.
module dm_timer_responder
  import dm_periph_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned PRESCALE    = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sel_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  data_select_i,
  input  logic        store_i,
  input  logic        load_i,
  output logic [31:0] data_o,
  output logic        load_done_o,
  output logic        store_done_o,
  output logic        ready_o,
  output logic        irq_o
);

  localparam int unsigned WW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  bus_state_e  state_q, state_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic        ready_q, ready_d;
  logic [1:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  mask_q, mask_d;
  logic        store_q, store_d;
  logic [31:0] data_q, data_d;

  logic [31:0] count, compare;
  logic [2:0]  ctrl;
  logic        match;
  logic [1:0]  rd_addr;
  logic [31:0] rd_data;
  logic        req;
  logic        wr_en;

  // With zero wait states the read happens on the accept edge, before addr_q is valid.
  assign rd_addr = (state_q == ST_IDLE) ? addr_i : addr_q;

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      REG_COUNT:   rd_data = count;
      REG_COMPARE: rd_data = compare;
      REG_CTRL:    rd_data = {29'd0, ctrl};
      REG_STATUS:  rd_data = {31'd0, match};
      default:     rd_data = '0;
    endcase
  end

  assign req = sel_i & (load_i | store_i) & ready_q;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    ready_d    = ready_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mask_d     = mask_q;
    store_d    = store_q;
    data_d     = data_q;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d  = addr_i;
          wdata_d = data_i;
          mask_d  = data_select_i;
          store_d = store_i;
          ready_d = 1'b0;
          if (WAIT_STATES == 0) begin
            state_d = ST_DONE;
            if (!store_i) data_d = rd_data;
          end else begin
            state_d    = ST_WAIT;
            wait_cnt_d = WW'(WAIT_STATES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == '0) begin
          state_d = ST_DONE;
          if (!store_q) data_d = rd_data;
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      ready_q    <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      mask_q     <= '0;
      store_q    <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      ready_q    <= ready_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mask_q     <= mask_d;
      store_q    <= store_d;
      data_q     <= data_d;
    end
  end

  assign wr_en        = (state_q == ST_DONE) & store_q;
  assign store_done_o = wr_en;
  assign load_done_o  = (state_q == ST_DONE) & ~store_q;
  assign ready_o      = ready_q;
  assign data_o       = data_q;

  dm_timer_core #(
    .PRESCALE (PRESCALE)
  ) u_core (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (wr_en),
    .wr_addr_i (addr_q),
    .wr_data_i (wdata_q),
    .wr_mask_i (mask_q),
    .count_o   (count),
    .compare_o (compare),
    .ctrl_o    (ctrl),
    .match_o   (match),
    .irq_o     (irq_o)
  );

endmodule

// File: tb/tb_dm_timer_responder.sv
// Directed bench for dm_timer_responder; completions are checked against a
// queue of expected responses filled when each request is issued.
module tb_dm_timer_responder;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        sel_i;
  logic [1:0]  addr_i;
  logic [31:0] data_i;
  logic [3:0]  data_select_i;
  logic        store_i;
  logic        load_i;
  logic [31:0] data_o;
  logic        load_done_o;
  logic        store_done_o;
  logic        ready_o;
  logic        irq_o;

  dm_timer_responder #(
    .WAIT_STATES (1),
    .PRESCALE    (16)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .sel_i         (sel_i),
    .addr_i        (addr_i),
    .data_i        (data_i),
    .data_select_i (data_select_i),
    .store_i       (store_i),
    .load_i        (load_i),
    .data_o        (data_o),
    .load_done_o   (load_done_o),
    .store_done_o  (store_done_o),
    .ready_o       (ready_o),
    .irq_o         (irq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_store;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   outstanding = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (load_done_o || store_done_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got load_done=%0b store_done=%0b expected no pulse",
                 load_done_o, store_done_o);
      end else begin
        mon_e = sb.pop_front();
        check("done_kind", 32'({load_done_o, store_done_o}),
              32'({~mon_e.is_store, mon_e.is_store}));
        if (!mon_e.is_store) check("load_data", data_o, mon_e.data);
        outstanding--;
      end
    end
  end

  task automatic push_exp(input logic st, input logic [31:0] d);
    exp_t e;
    e.is_store = st;
    e.data     = d;
    sb.push_back(e);
    outstanding++;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (outstanding != 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (outstanding != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d outstanding expected 0", name, outstanding);
      sb.delete();
      outstanding = 0;
    end
  endtask

  task automatic issue(input logic ld, input logic st, input logic [1:0] a,
                       input logic [31:0] d, input logic [3:0] m,
                       input logic [31:0] exp_rd, input string name);
    @(posedge clk);
    #1;
    check({name, "_ready"}, 32'(ready_o), 32'd1);
    push_exp(st, exp_rd);
    sel_i = 1'b1; load_i = ld; store_i = st;
    addr_i = a; data_i = d; data_select_i = m;
    @(posedge clk);
    #1;
    sel_i = 1'b0; load_i = 1'b0; store_i = 1'b0;
    wait_done(name);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] m,
                    input string name);
    issue(1'b0, 1'b1, a, d, m, 32'd0, name);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    issue(1'b1, 1'b0, a, 32'd0, 4'd0, exp, name);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1; sel_i = 1'b0; load_i = 1'b0; store_i = 1'b0;
    addr_i = '0; data_i = '0; data_select_i = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_dones", 32'({load_done_o, store_done_o}), 32'd0);
    check("rst_data", data_o, 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);

    // 1: load STATUS, ready low for two cycles, done in the second
    @(posedge clk);
    #1;
    push_exp(1'b0, 32'd0);
    sel_i = 1'b1; load_i = 1'b1; addr_i = 2'd3;
    @(posedge clk);
    #1;
    sel_i = 1'b0; load_i = 1'b0;
    check("t1_ready_c1", 32'(ready_o), 32'd0);
    check("t1_done_c1", 32'(load_done_o), 32'd0);
    @(posedge clk);
    #1;
    check("t1_ready_c2", 32'(ready_o), 32'd0);
    check("t1_done_c2", 32'(load_done_o), 32'd1);
    @(posedge clk);
    #1;
    check("t1_ready_c3", 32'(ready_o), 32'd1);
    wait_done("t1");

    // 2: compare match after 6 ticks of 16 clocks
    wr(2'd1, 32'd5, 4'hF, "t2_cmp");
    wr(2'd2, 32'd3, 4'hF, "t2_ctrl");
    @(posedge clk);
    repeat (95) @(posedge clk);
    #1;
    check("t2_irq_before", 32'(irq_o), 32'd0);
    @(posedge clk);
    #1;
    check("t2_irq_after", 32'(irq_o), 32'd1);
    rd(2'd3, 32'd1, "t2_status");
    wr(2'd3, 32'd1, 4'h1, "t2_w1c");
    @(posedge clk);
    #1;
    check("t2_irq_cleared", 32'(irq_o), 32'd0);
    rd(2'd3, 32'd0, "t2_status_clr");

    // 3: COUNT wraps to 0 without setting match
    wr(2'd2, 32'd0, 4'hF, "t3_dis");
    wr(2'd0, 32'hFFFF_FFFF, 4'hF, "t3_cnt");
    wr(2'd2, 32'd1, 4'hF, "t3_en");
    repeat (20) @(posedge clk);
    wr(2'd2, 32'd0, 4'hF, "t3_dis2");
    rd(2'd0, 32'd0, "t3_count");
    rd(2'd3, 32'd0, "t3_status");

    // 4: byte-lane merge, zero mask, CTRL upper bits
    wr(2'd0, 32'h1122_3344, 4'hF, "t4_full");
    wr(2'd0, 32'h0000_AB00, 4'b0010, "t4_lane1");
    rd(2'd0, 32'h1122_AB44, "t4_count");
    wr(2'd1, 32'hDEAD_BEEF, 4'h0, "t4_nomask");
    rd(2'd1, 32'd5, "t4_cmp");
    wr(2'd2, 32'hFFFF_FFF8, 4'hF, "t4_ctrl_hi");
    rd(2'd2, 32'd0, "t4_ctrl");

    // 5: load+store together is a store; request while busy is dropped
    @(posedge clk);
    #1;
    push_exp(1'b1, 32'd0);
    sel_i = 1'b1; load_i = 1'b1; store_i = 1'b1;
    addr_i = 2'd1; data_i = 32'd7; data_select_i = 4'hF;
    @(posedge clk);
    #1;
    check("t5_busy", 32'(ready_o), 32'd0);
    store_i = 1'b0; addr_i = 2'd0;
    @(posedge clk);
    #1;
    sel_i = 1'b0; load_i = 1'b0;
    wait_done("t5_both");
    repeat (4) @(posedge clk);
    rd(2'd1, 32'd7, "t5_cmp");

    // 6: reset in WAIT aborts the access
    wr(2'd0, 32'h0000_1234, 4'hF, "t6_cnt");
    wr(2'd2, 32'd6, 4'hF, "t6_ctrl");
    @(posedge clk);
    #1;
    sel_i = 1'b1; load_i = 1'b1; addr_i = 2'd0;
    @(posedge clk);
    #1;
    check("t6_in_wait", 32'(ready_o), 32'd0);
    sel_i = 1'b0; load_i = 1'b0; rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    check("t6_ready", 32'(ready_o), 32'd1);
    check("t6_data", data_o, 32'd0);
    repeat (3) @(posedge clk);
    rd(2'd0, 32'd0, "t6_count");
    rd(2'd1, 32'hFFFF_FFFF, "t6_cmp");
    rd(2'd2, 32'd0, "t6_ctrl");
    rd(2'd3, 32'd0, "t6_status");

    repeat (4) @(posedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
